// File: rtl/mm_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mm_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible request at or after ptr.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [PTR_W-1:0] grant,
  output logic             valid
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [N-1:0] eligible;

  assign eligible = req & mask;

  // Walk offsets from farthest to nearest so the nearest eligible core wins.
  always_comb begin
    logic [SUM_W-1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + SUM_W'(i);
      if (idx >= SUM_W'(N)) idx = idx - SUM_W'(N);
      if (eligible[idx[PTR_W-1:0]]) begin
        grant = idx[PTR_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data memory among NUM_CORES cores.
// Optional ARB_STATS_EN adds a saturating stat_conflicts counter.
module mem_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_write,
  output logic                          mem_read,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_data_in,
  input  logic [DATA_W-1:0]             mem_data_out
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_conflicts
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_CORES);

  arb_state_e state_q, state_d;
  logic [PTR_W-1:0]     sel_q, sel_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     next_ptr;
  logic [PTR_W-1:0]     pick_ptr;
  logic [NUM_CORES-1:0] pick_mask;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 write_d, read_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [NUM_CORES-1:0] ack_d;
  logic [DATA_W-1:0]    rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  assign next_ptr = (sel_q == PTR_W'(NUM_CORES - 1)) ? '0 : sel_q + PTR_W'(1);

  // In RESP the current core is excluded and search starts just past it.
  assign pick_ptr  = (state_q == RESP) ? next_ptr : rr_ptr_q;
  assign pick_mask = (state_q == RESP) ? ~(NUM_CORES'(1) << sel_q) : '1;

  rr_picker #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (core_req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    logic load;
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    write_d  = 1'b0;
    read_d   = 1'b0;
    addr_d   = mem_address;
    wdata_d  = mem_data_in;
    ack_d    = '0;
    rdata_d  = core_rdata;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) load = 1'b1;
      end
      ACCESS: begin
        state_d      = RESP;
        ack_d[sel_q] = 1'b1;
        if (mem_read) rdata_d = mem_data_out;
      end
      RESP: begin
        rr_ptr_d = next_ptr;
        if (pick_valid) load = 1'b1;
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Latch the granted core's fields straight into the memory-side registers.
    if (load) begin
      state_d = ACCESS;
      sel_d   = pick_idx;
      write_d = core_we[pick_idx];
      read_d  = ~core_we[pick_idx];
      addr_d  = addr_arr[pick_idx];
      wdata_d = wdata_arr[pick_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      core_ack    <= '0;
      core_rdata  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_write   <= write_d;
      mem_read    <= read_d;
      mem_address <= addr_d;
      mem_data_in <= wdata_d;
      core_ack    <= ack_d;
      core_rdata  <= rdata_d;
    end
  end

`ifdef ARB_STATS_EN
  // Two or more bits set iff clearing the lowest set bit leaves something.
  logic multi_req;
  assign multi_req = |(core_req & (core_req - NUM_CORES'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_conflicts <= '0;
    end else if (multi_req && (stat_conflicts != '1)) begin
      stat_conflicts <= stat_conflicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural data memory.
module tb_mem_arbiter;

  localparam int NC = 4;

  typedef struct {
    int          core;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] core_req;
  logic [NC-1:0] core_we;
  logic [63:0]   core_addr;
  logic [63:0]   core_wdata;
  logic [NC-1:0] core_ack;
  logic [15:0]   core_rdata;
  logic          mem_write;
  logic          mem_read;
  logic [15:0]   mem_address;
  logic [15:0]   mem_data_in;
  logic [15:0]   mem_data_out;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_conflicts;
`endif

  logic [15:0] mem [0:65535];
  logic        pre_done = 1'b0;
  int          wr_cnt = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          left [NC];
  exp_t        sbq [$];

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_ack     (core_ack),
    .core_rdata   (core_rdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
`ifdef ARB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preload on the first edge, then synchronous writes.
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (!pre_done) begin
      mem[16'd998] <= 16'd9;
      mem[16'd0]   <= 16'd10;
      mem[16'd500] <= 16'h0000;
      for (int i = 0; i < NC; i++) mem[16'd100 + 16'(i)] <= 16'h00A0 + 16'(i);
      mem[16'd200] <= 16'h0055;
      mem[16'd201] <= 16'h0066;
      pre_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address] <= mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic set_core(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    core_we[i]            = we;
    core_addr[i*16 +: 16]  = a;
    core_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    core_req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_req(input logic [NC-1:0] m, output int t0);
    @(posedge clk);
    #1 core_req = m;
    t0 = cyc;
  endtask

  task automatic push(input int core, input logic [15:0] rd, input int c);
    exp_t e;
    e.core  = core;
    e.rdata = rd;
    e.cyc   = c;
    sbq.push_back(e);
  endtask

  // Models the cores: drop req on the edge ending ack, re-raise a cycle later if more is wanted.
  task automatic run_acks(input int n_acks, input int budget);
    int          seen = 0;
    int          waited = 0;
    logic [NC-1:0] drop;
    logic [NC-1:0] raise_pend = '0;
    exp_t        e;
    while (seen < n_acks && waited < budget) begin
      @(negedge clk);
      waited++;
      drop = '0;
      for (int i = 0; i < NC; i++) begin
        if (core_ack[i]) begin
          drop[i] = 1'b1;
          seen++;
          if (left[i] > 0) left[i]--;
          n_chk++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected core=%0d cycle=%0d required no ack", i, cyc);
          end else begin
            e = sbq.pop_front();
            if (i != e.core || cyc != e.cyc || core_rdata !== e.rdata) begin
              n_fail++;
              $display("FAIL ack_check got core=%0d cycle=%0d rdata=%h required core=%0d cycle=%0d rdata=%h",
                       i, cyc, core_rdata, e.core, e.cyc, e.rdata);
            end
          end
        end
      end
      @(posedge clk);
      #1;
      core_req = (core_req | raise_pend) & ~drop;
      for (int i = 0; i < NC; i++) raise_pend[i] = drop[i] && (left[i] > 0);
    end
    n_chk++;
    if (seen < n_acks || sbq.size() != 0) begin
      n_fail++;
      $display("FAIL ack_count got %0d acks, %0d expected left required %0d acks, 0 left",
               seen, sbq.size(), n_acks);
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    logic [NC-1:0] req_seen;
    reset = 1'b1;
    core_req = '0;
    #3;
    n_chk++;
    if (core_ack !== '0 || core_rdata !== '0 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
        mem_address !== '0 || mem_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b rdata=%h wr=%b rd=%b addr=%h din=%h required all zero",
               core_ack, core_rdata, mem_write, mem_read, mem_address, mem_data_in);
    end
    core_req = 4'hF;
    req_seen = core_req;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (core_ack !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_holds got ack=%b rd=%b wr=%b with req=%b required idle", core_ack, mem_read, mem_write, req_seen);
    end
    core_req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_read();
    int t0;
    set_core(1, 1'b0, 16'd998, 16'h0);
    left = '{0, 0, 0, 0};
    start_req(4'b0010, t0);
    push(1, 16'd9, t0 + 2);
    run_acks(1, 10);
  endtask

  task automatic test_write_read();
    int t0;
    int w0;
    w0 = wr_cnt;
    set_core(0, 1'b1, 16'd500, 16'h1234);
    set_core(2, 1'b0, 16'd500, 16'h0BAD);
    left = '{0, 0, 0, 0};
    start_req(4'b0001, t0);
    push(0, 16'd9, t0 + 2);
    run_acks(1, 10);
    start_req(4'b0100, t0);
    push(2, 16'h1234, t0 + 2);
    run_acks(1, 10);
    repeat (2) @(negedge clk);
    n_chk++;
    if (wr_cnt - w0 != 1) begin
      n_fail++;
      $display("FAIL write_strobe_cycles got %0d required 1", wr_cnt - w0);
    end
    n_chk++;
    if (mem_address !== 16'd500 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got addr=%0d rd=%b wr=%b required addr=500 rd=0 wr=0", mem_address, mem_read, mem_write);
    end
  endtask

  task automatic test_all_four();
    int t0;
    do_reset();
    for (int i = 0; i < NC; i++) set_core(i, 1'b0, 16'd100 + 16'(i), 16'h0);
    left = '{0, 0, 0, 0};
    start_req(4'b1111, t0);
    for (int i = 0; i < NC; i++) push(i, 16'h00A0 + 16'(i), t0 + 2 + 2 * i);
    run_acks(4, 20);
  endtask

  task automatic test_no_starve();
    int t0;
    do_reset();
    set_core(0, 1'b0, 16'd200, 16'h0);
    set_core(3, 1'b0, 16'd201, 16'h0);
    left = '{3, 0, 0, 3};
    start_req(4'b1001, t0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(0, 16'h0055, t0 + 2 + 2 * k);
      else            push(3, 16'h0066, t0 + 2 + 2 * k);
    end
    run_acks(6, 30);
  endtask

  task automatic test_reset_abort();
    int t0;
    int w0;
    int acks = 0;
    do_reset();
    w0 = wr_cnt;
    set_core(0, 1'b1, 16'd0, 16'hFFFF);
    left = '{0, 0, 0, 0};
    start_req(4'b0001, t0);
    @(posedge clk);
    #1;
    n_chk++;
    if (mem_write !== 1'b1 || mem_address !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_access got wr=%b addr=%h required wr=1 addr=0", mem_write, mem_address);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async_drop got wr=%b required 0", mem_write);
    end
    core_req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (core_ack !== '0) acks++;
    end
    n_chk++;
    if (acks != 0 || wr_cnt != w0) begin
      n_fail++;
      $display("FAIL abort_no_effect got acks=%0d writes=%0d required 0 and 0", acks, wr_cnt - w0);
    end
    set_core(1, 1'b0, 16'd0, 16'h0);
    start_req(4'b0010, t0);
    push(1, 16'd10, t0 + 2);
    run_acks(1, 10);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    int t0;
    do_reset();
    set_core(0, 1'b0, 16'd0, 16'h0);
    set_core(1, 1'b0, 16'd0, 16'h0);
    start_req(4'b0011, t0);
    repeat (5) @(posedge clk);
    #1 core_req = '0;
    n_chk++;
    if (stat_conflicts !== 16'd5) begin
      n_fail++;
      $display("FAIL stat_count got %0d required 5", stat_conflicts);
    end
    repeat (6) @(posedge clk);
    #1 force dut.stat_conflicts = 16'hFFFF;
    #1 release dut.stat_conflicts;
    core_req = 4'b0011;
    repeat (3) @(posedge clk);
    #1 core_req = '0;
    n_chk++;
    if (stat_conflicts !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stat_saturate got %h required ffff", stat_conflicts);
    end
    repeat (8) @(posedge clk);
    do_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_all_four();
    test_no_starve();
    test_reset_abort();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, memory data width.
REQ-004 SHALL have port clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port core_req  in  NUM_CORES  per-core access request, held high until ack.
REQ-007 SHALL have port core_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
REQ-008 SHALL have port core_addr  in  NUM_CORES*ADDR_W  per-core address, packed with core 0 in the LSBs.
REQ-009 SHALL have port core_wdata  in  NUM_CORES*DATA_W  per-core write data, packed the same way.
REQ-010 SHALL have port core_ack  out  NUM_CORES  one-cycle pulse marking completion of an access.
REQ-011 SHALL have port core_rdata  out  DATA_W  registered read data, shared by all cores, valid while ack is high.
REQ-012 SHALL have port mem_write  out  1  write strobe to data memory.
REQ-013 SHALL have port mem_read  out  1  read strobe to data memory.
REQ-014 SHALL have port mem_address  out  ADDR_W  address to data memory.
REQ-015 SHALL have port mem_data_in  out  DATA_W  write data to data memory.
REQ-016 SHALL have port mem_data_out  in  DATA_W  combinational read data from data memory.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-018 In IDLE, if any core_req is high, SHALL select a core by round-robin starting at rr_ptr, latch that core's we/addr/wdata and go to ACCESS.
REQ-019 In ACCESS, SHALL drive the latched fields: mem_write = we, mem_read = !we; the memory writes on the edge that ends ACCESS.
REQ-020 On the edge that ends ACCESS, SHALL capture mem_data_out into core_rdata for reads, leave core_rdata unchanged for writes, and go to RESP.
REQ-021 In RESP, SHALL drive core_ack[sel] = 1 and set rr_ptr = (sel+1) mod NUM_CORES.
REQ-022 In RESP, if any core other than sel has core_req high, SHALL arbitrate among those cores and go directly to ACCESS; otherwise SHALL go to IDLE.
REQ-023 Latency SHALL be: request first seen high in cycle t gives ack in cycle t+2; back-to-back accesses complete one per 2 cycles.
REQ-024 Cores SHALL deassert core_req on the edge ending their ack cycle; a request still high in IDLE is treated as a new access.
REQ-025 Outside ACCESS, mem_write and mem_read SHALL be 0 and mem_address/mem_data_in SHALL hold their last values.
REQ-026 Addresses SHALL be passed through unchecked (no range limit).
REQ-027 A simultaneous new request and ack to another core SHALL lose no request.

Reset
REQ-028 Reset SHALL force state = IDLE, rr_ptr = 0, core_ack = 0, core_rdata = 0, mem_write = 0, mem_read = 0, mem_address = 0 and mem_data_in = 0, immediately and independent of clk.
REQ-029 Reset asserted during ACCESS SHALL drop mem_write at once, so no memory write occurs; the aborted access is never acked.

Configuration
REQ-030 When ARB_STATS_EN is defined, SHALL add output stat_conflicts [15:0], reset to 0, incremented (saturating at 0xFFFF) in each cycle where two or more core_req bits are high.
REQ-031 When ARB_STATS_EN is undefined, the stat_conflicts port and its counter SHALL be absent.

Structure
REQ-032 Package mm_arb_pkg SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-033 Sub-module rr_picker SHALL be purely combinational: inputs request vector, rr_ptr and mask; outputs grant index and a valid flag.

Verification
REQ-034 After reset, core 1 reads address 998 (preloaded 9): ack[1] in cycle t+2 and core_rdata = 9.
REQ-035 Core 0 writes 500 <= 0x1234, then core 2 reads address 500: core_rdata = 0x1234, and mem_write was high for exactly one cycle.
REQ-036 All four cores request in the same cycle after reset: acks arrive in order 0, 1, 2, 3 at cycles t+2, t+4, t+6, t+8.
REQ-037 Core 3 holds its request while core 0 re-requests continuously: ack order alternates 0, 3, 0, 3, and core 3 is never starved.
REQ-038 Reset asserted in ACCESS of a write of 0xFFFF to address 0 (preloaded 10): address 0 still reads 10, and no ack occurs.
REQ-039 With ARB_STATS_EN defined, cores 0 and 1 both request for 5 cycles: stat_conflicts = 5; a forced count of 0xFFFF stays at 0xFFFF.
